hazard_scoreboard: RTL

- Pipeline hazard controller for the 5-stage vector CPU (Fetch, Decode, Execute, Memory, WriteBack).
- Tracks in-flight register writes with separate scalar and vector scoreboards.
- Generates stall and flush controls for the PC, the Fetch/Decode register and the Decode/Execute register, so that RAW/WAW hazards and taken branches resolve without forwarding.
- Sits beside controlUnit: reads Decode-stage fields, Execute-stage branch decision and WriteBack-stage retire info.

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard.sv | 62 ++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: Decode/Execute/WriteBack hazard fields and the stall/flush controls
// returned to the pipeline.
interface hazard_scoreboard_if #(
    parameter int REG_ADDRESS_WIDTH = 4,
    parameter int STALL_COUNT_WIDTH = 16
);
    logic [REG_ADDRESS_WIDTH-1:0] reg1AddressD;
    logic [REG_ADDRESS_WIDTH-1:0] reg2AddressD;
    logic                         useReg1D;
    logic                         useReg2D;
    logic                         isScalarReg1D;
    logic                         isScalarReg2D;
    logic [REG_ADDRESS_WIDTH-1:0] regDestinationAddressD;
    logic                         writeEnableScalarD;
    logic                         writeEnableVectorD;
    logic                         validD;
    logic                         takeBranchE;
    logic [REG_ADDRESS_WIDTH-1:0] retireAddressWB;
    logic                         retireScalarWB;
    logic                         retireVectorWB;
    logic                         stallF;
    logic                         stallD;
    logic                         flushD;
    logic                         flushE;
    logic                         issueD;
    logic [STALL_COUNT_WIDTH-1:0] stallCount;

    modport master (
        output reg1AddressD, reg2AddressD, useReg1D, useReg2D, isScalarReg1D, isScalarReg2D,
               regDestinationAddressD, writeEnableScalarD, writeEnableVectorD, validD,
               takeBranchE, retireAddressWB, retireScalarWB, retireVectorWB,
        input  stallF, stallD, flushD, flushE, issueD, stallCount
    );

    modport slave (
        input  reg1AddressD, reg2AddressD, useReg1D, useReg2D, isScalarReg1D, isScalarReg2D,
               regDestinationAddressD, writeEnableScalarD, writeEnableVectorD, validD,
               takeBranchE, retireAddressWB, retireScalarWB, retireVectorWB,
        output stallF, stallD, flushD, flushE, issueD, stallCount
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: scalar/vector pending-write scoreboards that stall RAW/WAW hazards and
// flush on taken branches, with a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int SCALAR_REGNUM     = 16,
    parameter int VECTOR_REGNUM     = 8,
    parameter int REG_ADDRESS_WIDTH = 4,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input logic clock,
    input logic reset,
    hazard_scoreboard_if.slave bus
);
    logic [SCALAR_REGNUM-1:0]     scalarPending;
    logic [VECTOR_REGNUM-1:0]     vectorPending;
    logic [STALL_COUNT_WIDTH-1:0] stallCount;
    logic                         hazard;
    logic                         src1Hit;
    logic                         src2Hit;
    logic                         wawHit;

    // Out-of-range addresses shift the one-hot bit off the end, so they never match or set.
    function automatic logic [SCALAR_REGNUM-1:0] scalarMask(input logic [REG_ADDRESS_WIDTH-1:0] a);
        return SCALAR_REGNUM'(1) << a;
    endfunction

    function automatic logic [VECTOR_REGNUM-1:0] vectorMask(input logic [REG_ADDRESS_WIDTH-1:0] a);
        return VECTOR_REGNUM'(1) << a;
    endfunction

    always_comb begin
        src1Hit = bus.useReg1D & (bus.isScalarReg1D ? |(scalarPending & scalarMask(bus.reg1AddressD))
                                                    : |(vectorPending & vectorMask(bus.reg1AddressD)));
        src2Hit = bus.useReg2D & (bus.isScalarReg2D ? |(scalarPending & scalarMask(bus.reg2AddressD))
                                                    : |(vectorPending & vectorMask(bus.reg2AddressD)));
        wawHit  = (bus.writeEnableScalarD & |(scalarPending & scalarMask(bus.regDestinationAddressD)))
                | (bus.writeEnableVectorD & |(vectorPending & vectorMask(bus.regDestinationAddressD)));
        hazard  = bus.validD & (src1Hit | src2Hit | wawHit);
    end

    assign bus.flushD     = !reset & bus.takeBranchE;
    assign bus.flushE     = !reset & (bus.takeBranchE | hazard);
    assign bus.stallF     = !reset & !bus.takeBranchE & hazard;
    assign bus.stallD     = bus.stallF;
    assign bus.issueD     = !reset & !bus.takeBranchE & !hazard & bus.validD;
    assign bus.stallCount = stallCount;

    // Set is OR-ed after the clear so a same-edge set/retire of one register leaves it pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scalarPending <= '0;
            vectorPending <= '0;
            stallCount    <= '0;
        end else begin
            scalarPending <= (scalarPending & ~(bus.retireScalarWB ? scalarMask(bus.retireAddressWB) : '0))
                           | (bus.issueD && bus.writeEnableScalarD ? scalarMask(bus.regDestinationAddressD) : '0);
            vectorPending <= (vectorPending & ~(bus.retireVectorWB ? vectorMask(bus.retireAddressWB) : '0))
                           | (bus.issueD && bus.writeEnableVectorD ? vectorMask(bus.regDestinationAddressD) : '0);
            if (bus.stallD && stallCount != '1)
                stallCount <= stallCount + 1'b1;
        end
    end
endmodule
